// File: rtl/cordic_pkg.sv
// ------------------------------------------------------------------
// cordic_pkg : shared constants and command record for the sequencer
// Revision   : 1.0
// ------------------------------------------------------------------
`default_nettype none

package cordic_pkg;

  localparam int FIXED_W = 16;
  localparam int ALPHA_W = 5;

  localparam logic [1:0] CIRC = 2'b00;
  localparam logic [1:0] LIN  = 2'b01;
  localparam logic [1:0] HYP  = 2'b10;

  localparam logic [1:0] REG_CTRL     = 2'd0;
  localparam logic [1:0] REG_OPERANDS = 2'd1;
  localparam logic [1:0] REG_RESULT   = 2'd2;
  localparam logic [1:0] REG_STATUS   = 2'd3;

  localparam int CTRL_GO       = 0;
  localparam int CTRL_ROT      = 1;
  localparam int CTRL_MODE_LO  = 2;
  localparam int CTRL_ALPHA_LO = 4;
  localparam int CTRL_IRQ_EN   = 9;

  localparam int ST_BUSY   = 0;
  localparam int ST_VALID  = 1;
  localparam int ST_FULL   = 2;
  localparam int ST_OVF    = 3;
  localparam int ST_TMO    = 4;
  localparam int ST_CNT_LO = 6;

  typedef struct packed {
    logic               is_rotating;
    logic [1:0]         mode;
    logic [ALPHA_W-1:0] alpha_shift;
    logic [FIXED_W-1:0] a;
    logic [FIXED_W-1:0] b;
  } cmd_t;

endpackage

`default_nettype wire

// File: rtl/cordic_cmd_fifo.sv
// ------------------------------------------------------------------
// cordic_cmd_fifo : synchronous FIFO of command records
// Revision        : 1.0
// ------------------------------------------------------------------
`default_nettype none

module cordic_cmd_fifo
  import cordic_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  cmd_t             push_data,
  input  logic             pop,
  output cmd_t             head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // a push while full is still accepted when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/cordic_cmd_sequencer.sv
// ------------------------------------------------------------------
// cordic_cmd_sequencer : bus register front-end issuing queued CORDIC commands
// Revision             : 1.0
// ------------------------------------------------------------------
`default_nettype none

module cordic_cmd_sequencer
  import cordic_pkg::*;
#(
  parameter int FIXED_WIDTH    = 16,
  parameter int QUEUE_DEPTH    = 2,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int SHIFT_W        = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             addr,
  input  logic [31:0]            wdata,
  input  logic                   wr_en,
  input  logic                   rd_en,
  output logic [31:0]            rdata,
  output logic                   irq,
  output logic                   cordic_start,
  output logic                   cordic_is_rotating,
  output logic [1:0]             cordic_mode,
  output logic [SHIFT_W-1:0]     cordic_alpha_shift,
  output logic [FIXED_WIDTH-1:0] cordic_a,
  output logic [FIXED_WIDTH-1:0] cordic_b,
  input  logic [FIXED_WIDTH-1:0] cordic_out1,
  input  logic [FIXED_WIDTH-1:0] cordic_out2,
  input  logic                   cordic_done
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                 state;
  state_t                 next_state;
  logic                   load_hold;
  logic                   capture;
  logic                   expire;

  cmd_t                   hold;
  cmd_t                   push_cmd;
  cmd_t                   fifo_head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CNT_W-1:0]       fifo_count;

  logic [FIXED_WIDTH-1:0] ops_a;
  logic [FIXED_WIDTH-1:0] ops_b;
  logic [FIXED_WIDTH-1:0] res1;
  logic [FIXED_WIDTH-1:0] res2;
  logic                   result_valid;
  logic                   overflow;
  logic                   timeout;
  logic                   irq_en;
  logic [TMO_W-1:0]       wait_cnt;

  logic                   wr_ctrl;
  logic                   wr_ops;
  logic                   wr_status;
  logic                   go;
  logic                   rd_result;
  logic                   busy;
  logic                   expired;
  logic                   unused_addr_bits;

  assign wr_ctrl          = wr_en && (addr[3:2] == REG_CTRL);
  assign wr_ops           = wr_en && (addr[3:2] == REG_OPERANDS);
  assign wr_status        = wr_en && (addr[3:2] == REG_STATUS);
  assign rd_result        = rd_en && (addr[3:2] == REG_RESULT);
  assign go               = wr_ctrl && wdata[CTRL_GO];
  assign busy             = (state != S_IDLE) || !fifo_empty;
  assign unused_addr_bits = ^addr[1:0];
  // the start cycle counts as cycle 1, so the flag appears TIMEOUT_CYCLES after start
  assign expired          = (wait_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // operands are taken from the register as it stood before this cycle's writes
  always_comb begin
    push_cmd             = '0;
    push_cmd.is_rotating = wdata[CTRL_ROT];
    push_cmd.mode        = wdata[CTRL_MODE_LO +: 2];
    push_cmd.alpha_shift = wdata[CTRL_ALPHA_LO +: ALPHA_W];
    push_cmd.a           = ops_a;
    push_cmd.b           = ops_b;
  end

  cordic_cmd_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (go),
    .push_data (push_cmd),
    .pop       (load_hold),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // The head is popped on entry to ISSUE so the held fields are already valid during the start pulse.
  always_comb begin
    next_state = state;
    load_hold  = 1'b0;
    capture    = 1'b0;
    expire     = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty && !result_valid) begin
          next_state = S_ISSUE;
          load_hold  = 1'b1;
        end
      end
      S_ISSUE: next_state = S_WAIT;
      S_WAIT: begin
        if (cordic_done) begin
          capture    = 1'b1;
          next_state = S_IDLE;
        end else if (expired) begin
          expire     = 1'b1;
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold         <= '0;
      ops_a        <= '0;
      ops_b        <= '0;
      res1         <= '0;
      res2         <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
      timeout      <= 1'b0;
      irq_en       <= 1'b0;
      wait_cnt     <= '0;
    end else begin
      if (wr_ctrl)   irq_en <= wdata[CTRL_IRQ_EN];
      if (wr_ops)    {ops_b, ops_a} <= wdata;
      if (load_hold) hold <= fifo_head;

      if (state == S_ISSUE)     wait_cnt <= TMO_W'(1);
      else if (state == S_WAIT) wait_cnt <= wait_cnt + 1'b1;

      // a read clearing the old result loses to a capture of the new one
      if (rd_result) result_valid <= 1'b0;
      if (capture) begin
        res1         <= cordic_out1;
        res2         <= cordic_out2;
        result_valid <= 1'b1;
      end

      if (wr_status && wdata[ST_OVF])      overflow <= 1'b0;
      if (go && fifo_full && !load_hold)   overflow <= 1'b1;
      if (wr_status && wdata[ST_TMO])      timeout  <= 1'b0;
      if (expire)                          timeout  <= 1'b1;
    end
  end

  always_comb begin
    rdata = '0;
    case (addr[3:2])
      REG_OPERANDS: rdata = {ops_b, ops_a};
      REG_RESULT:   rdata = {res2, res1};
      REG_STATUS: begin
        rdata[ST_BUSY]          = busy;
        rdata[ST_VALID]         = result_valid;
        rdata[ST_FULL]          = fifo_full;
        rdata[ST_OVF]           = overflow;
        rdata[ST_TMO]           = timeout;
        rdata[ST_CNT_LO +: 2]   = 2'(fifo_count);
      end
      default: ;
    endcase
  end

  assign irq                = irq_en && (result_valid || timeout);
  assign cordic_start       = (state == S_ISSUE);
  assign cordic_is_rotating = hold.is_rotating;
  assign cordic_mode        = hold.mode;
  assign cordic_alpha_shift = hold.alpha_shift;
  assign cordic_a           = hold.a;
  assign cordic_b           = hold.b;

endmodule

`default_nettype wire
